// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_rx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO with wrap-bit pointers.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic              clk_core,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  count
);

    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign count = wptr - rptr;

    // A pop on an empty FIFO is ignored; a pop frees the slot for a same-cycle push when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_data = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_core) begin
        if (do_push) mem[wptr[FIFO_AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT FIFO with sticky error flags.
// Optional flow control: define UART_RX_CTS_EN to drive cts_n from FIFO free space.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic              clk_core,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clear,
    output logic              cts_n
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = 3;

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic              rx_meta;
    logic              rxs;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_idx_nxt;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] shreg_nxt;
    logic              expire_c;
    logic              push_c;
    logic              ferr_set_c;
    logic              overrun_set_c;

    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    assign expire_c = (cnt <= CNT_W'(1));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push_c      = 1'b0;
        ferr_set_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_nxt   = CNT_W'(CLKS_PER_BIT / 2);
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (expire_c) begin
                    if (!rxs) begin
                        cnt_nxt     = CNT_W'(CLKS_PER_BIT);
                        bit_idx_nxt = '0;
                        state_nxt   = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (expire_c) begin
                    shreg_nxt = {rxs, shreg[BYTE_W-1:1]};
                    cnt_nxt   = CNT_W'(CLKS_PER_BIT);
                    if (bit_idx == BIT_W'(BYTE_W - 1)) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (expire_c) begin
                    if (rxs) begin
                        push_c    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_nxt  = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_core  (clk_core),
        .reset     (reset),
        .push      (push_c),
        .push_data (shreg),
        .pop       (rd_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = fifo_empty ? '0 : fifo_head;

    // A pop in the same cycle makes room, so only a push into a full, unread FIFO overruns.
    assign overrun_set_c = push_c & fifo_full & ~(rd_ready & rd_valid);

    // Sticky flags: a new event in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set_c    | (frame_err & ~err_clear);
            overrun   <= overrun_set_c | (overrun   & ~err_clear);
        end
    end

`ifdef UART_RX_CTS_EN
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [FIFO_AW:0] free_slots;

    assign free_slots = (FIFO_AW+1)'(DEPTH) - fifo_count;

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            cts_n <= 1'b0;
        end else begin
            cts_n <= (free_slots <= (FIFO_AW+1)'(2));
        end
    end
`else
    assign cts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: serial stimulus, FIFO drain compared against a queue.
module tb_uart_rx_buffered;
    import uart_rx_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;
    logic       cts_n;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pop_cnt  = 0;
    logic [7:0] exp_q[$];

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (3)
    ) dut (
        .clk_core  (clk_core),
        .reset     (reset),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clear (err_clear),
        .cts_n     (cts_n)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Consumer side: every accepted head byte must match the oldest expected byte.
    always @(negedge clk_core) begin
        if (!reset && rd_valid && rd_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            pop_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_core);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
        bit_time(1'b1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        tick(2);
    endtask

    initial begin
        int p;
        logic [7:0] b;
        reset     = 1'b1;
        rx        = 1'b1;
        rd_ready  = 1'b0;
        err_clear = 1'b0;
        tick(3);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_cts_n",     32'(cts_n),     32'd0);
        check("rst_state",     32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0;
        tick(3);

        // Single clean byte
        rd_ready = 1'b1;
        p = pop_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_drain(300);
        check("a5_pops",      32'(pop_cnt - p), 32'd1);
        check("a5_frame_err", 32'(frame_err),   32'd0);
        check("a5_rd_valid",  32'(rd_valid),    32'd0);

        // Short low glitch is a false start
        p = pop_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        check("glitch_state",    32'(dut.state),   32'(ST_IDLE));
        check("glitch_rd_valid", 32'(rd_valid),    32'd0);
        check("glitch_pops",     32'(pop_cnt - p), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_drain(300);

        // Low stop bit: framing error, nothing stored
        p = pop_cnt;
        send_byte(8'h3C, 1'b0);
        check("ferr_set",      32'(frame_err),   32'd1);
        check("ferr_pops",     32'(pop_cnt - p), 32'd0);
        check("ferr_rd_valid", 32'(rd_valid),    32'd0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        tick(1);
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Nine bytes into an eight-deep FIFO with no reader
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'(i + 1);
            if (i < 8) exp_q.push_back(b);
            send_byte(b, 1'b1);
`ifdef UART_RX_CTS_EN
            check("fill_cts_n", 32'(cts_n), 32'((i + 1) >= 6));
`else
            check("fill_cts_n", 32'(cts_n), 32'd0);
`endif
            check("fill_overrun", 32'(overrun), 32'(i == 8));
        end
        check("full_rd_valid", 32'(rd_valid), 32'd1);
        check("full_head",     32'(rd_data),  32'h01);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        tick(1);
        check("ovr_cleared", 32'(overrun), 32'd0);
        p = pop_cnt;
        rd_ready = 1'b1;
        wait_drain(100);
        check("drain_pops",     32'(pop_cnt - p), 32'd8);
        check("drain_rd_valid", 32'(rd_valid),    32'd0);
        check("drain_cts_n",    32'(cts_n),       32'd0);

        // Reset during bit 4 abandons the frame
        p = pop_cnt;
        b = 8'h55;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b[i]);
        rx = b[4];
        tick(5);
        reset = 1'b1;
        tick(CPB - 5);
        for (int i = 5; i < 8; i++) bit_time(b[i]);
        bit_time(1'b1);
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        bit_time(1'b1);
        reset = 1'b0;
        tick(5);
        check("post_rst_rd_valid",  32'(rd_valid),    32'd0);
        check("post_rst_pops",      32'(pop_cnt - p), 32'd0);
        check("post_rst_frame_err", 32'(frame_err),   32'd0);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_drain(300);
        check("post_rst_rx_pops", 32'(pop_cnt - p), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
